simon_sequencer: RTL and testbench

SIMON_SEQUENCER -- requirements
Module: simon_sequencer

---
 rtl/simon_sequencer.sv | 142 ++++++++++++++
 tb/tb_simon_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// Simon memory game sequencer: generates, shows and checks a growing pattern.
// Optional LISTEN timeout is enabled with `define SIMON_TIMEOUT_EN.
module simon_sequencer #(
  parameter int MAX_LEN        = 16,
  parameter int ON_CYCLES      = 4,
  parameter int OFF_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] player_num,
  input  logic       player_pressed,
  output logic       simon_turn,
  output logic [1:0] simon_num,
  output logic       simon_pressed,
  output logic [4:0] round,
  output logic       game_over,
  output logic       win
);

  localparam int AW   = $clog2(MAX_LEN);
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, GEN, SHOW_ON, SHOW_OFF, LISTEN, OVER, WIN
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [1:0]    mem [MAX_LEN];
  logic [4:0]    idx;
  logic [TW-1:0] timer;
  logic          lfsrFb;
  logic          timedOut;

  // x^8+x^6+x^5+x^4+1, maximal length so a nonzero seed never hits zero
  assign lfsrFb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

`ifdef SIMON_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] toCnt;

  always_ff @(posedge clk) begin
    if (reset || state != LISTEN || player_pressed)
      toCnt <= '0;
    else
      toCnt <= toCnt + 1'b1;
  end

  assign timedOut = (toCnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timedOut = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lfsr          <= 8'hA5;
      idx           <= '0;
      timer         <= '0;
      simon_turn    <= 1'b0;
      simon_num     <= 2'd0;
      simon_pressed <= 1'b0;
      round         <= 5'd0;
      game_over     <= 1'b0;
      win           <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsrFb};
      unique case (state)
        IDLE, OVER, WIN: begin
          if (start) begin
            state      <= GEN;
            round      <= 5'd1;
            simon_turn <= 1'b1;
            game_over  <= 1'b0;
            win        <= 1'b0;
          end
        end
        GEN: begin
          mem[AW'(round - 5'd1)] <= lfsr[1:0];
          idx           <= '0;
          timer         <= '0;
          state         <= SHOW_ON;
          simon_pressed <= 1'b1;
          // element 0 is the one being written when the round is 1
          simon_num     <= (round == 5'd1) ? lfsr[1:0] : mem[0];
        end
        SHOW_ON: begin
          if (timer == TW'(ON_CYCLES - 1)) begin
            timer         <= '0;
            state         <= SHOW_OFF;
            simon_pressed <= 1'b0;
            simon_num     <= 2'd0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SHOW_OFF: begin
          if (timer == TW'(OFF_CYCLES - 1)) begin
            timer <= '0;
            if (idx == round - 5'd1) begin
              idx        <= '0;
              state      <= LISTEN;
              simon_turn <= 1'b0;
            end else begin
              idx           <= idx + 5'd1;
              state         <= SHOW_ON;
              simon_pressed <= 1'b1;
              simon_num     <= mem[AW'(idx + 5'd1)];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LISTEN: begin
          if (player_pressed) begin
            if (player_num != mem[AW'(idx)]) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else if (idx != round - 5'd1) begin
              idx <= idx + 5'd1;
            end else if (round == 5'(MAX_LEN)) begin
              state <= WIN;
              win   <= 1'b1;
            end else begin
              round      <= round + 5'd1;
              state      <= GEN;
              simon_turn <= 1'b1;
            end
          end else if (timedOut) begin
            state     <= OVER;
            game_over <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Scoreboard bench for simon_sequencer (MAX_LEN=2, default show timing).
module tb_simon_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] player_num = 2'd0;
  logic       player_pressed = 1'b0;
  logic       simon_turn;
  logic [1:0] simon_num;
  logic       simon_pressed;
  logic [4:0] round;
  logic       game_over;
  logic       win;

  simon_sequencer #(.MAX_LEN(2)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .player_num(player_num),
    .player_pressed(player_pressed),
    .simon_turn(simon_turn),
    .simon_num(simon_num),
    .simon_pressed(simon_pressed),
    .round(round),
    .game_over(game_over),
    .win(win)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      nm;
    logic       t;
    logic       p;
    logic       g;
    logic       w;
    logic [4:0] r;
    logic       cn;
    logic [1:0] n;
  } exp_t;

  exp_t       sb[$];
  exp_t       monE;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] shown [4];

  task automatic pushAt(input int at, input string nm,
                        input logic t, input logic p,
                        input logic g, input logic w,
                        input int r, input logic cn,
                        input logic [1:0] n);
    exp_t e;
    e.at = at; e.nm = nm;
    e.t = t; e.p = p; e.g = g; e.w = w;
    e.r = 5'(r); e.cn = cn; e.n = n;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      monE = sb.pop_front();
      checks++;
      if (monE.at != cyc || simon_turn !== monE.t ||
          simon_pressed !== monE.p || game_over !== monE.g ||
          win !== monE.w || round !== monE.r ||
          (monE.cn && simon_num !== monE.n)) begin
        errors++;
        $display("FAIL %s cyc=%0d at=%0d got t%b p%b g%b w%b r%0d n%0d exp t%b p%b g%b w%b r%0d n%0d",
                 monE.nm, cyc, monE.at, simon_turn, simon_pressed,
                 game_over, win, round, simon_num, monE.t, monE.p,
                 monE.g, monE.w, monE.r, monE.n);
      end
    end
  end

  // t0 is the negedge on which the GEN-triggering input was driven
  task automatic showRound(input int t0, input int rnd, input int nKnown);
    for (int k = 1; k <= 6 * rnd + 2; k++) begin
      int el, ph;
      el = (k - 2) / 6;
      ph = (k - 2) % 6;
      if (k == 1)
        pushAt(t0 + k, "gen", 1, 0, 0, 0, rnd, 1, 2'd0);
      else if (k == 6 * rnd + 2)
        pushAt(t0 + k, "listen", 0, 0, 0, 0, rnd, 1, 2'd0);
      else if (ph < 4)
        pushAt(t0 + k, "show_on", 1, 1, 0, 0, rnd, el < nKnown,
               (el < nKnown) ? shown[el] : 2'd0);
      else
        pushAt(t0 + k, "show_off", 1, 0, 0, 0, rnd, 1, 2'd0);
    end
    @(negedge clk);
    start = 1'b0;
    player_pressed = 1'b0;
    for (int i = 0; i < rnd; i++) begin
      while (cyc < t0 + 2 + 6 * i) @(negedge clk);
      shown[i] = simon_num;
    end
    while (cyc < t0 + 2 + 6 * rnd) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    pushAt(cyc + 1, "reset", 0, 0, 0, 0, 0, 1, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    pushAt(cyc + 1, "idle", 0, 0, 0, 0, 0, 1, 2'd0);
  endtask

  task automatic launch(input int nKnown);
    repeat (2) @(negedge clk);
    start = 1'b1;
    showRound(cyc, 1, nKnown);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    @(negedge clk);
    doReset();
    launch(0);

    player_num = shown[0];
    player_pressed = 1'b1;
    showRound(cyc, 2, 1);

    player_num = shown[0] + 2'd1;
    player_pressed = 1'b1;
    pushAt(cyc + 1, "wrong", 0, 0, 1, 0, 2, 1, 2'd0);
    @(negedge clk);
    player_pressed = 1'b0;
    @(negedge clk);
    player_num = shown[0];
    player_pressed = 1'b1;
    pushAt(cyc + 1, "over_hold", 0, 0, 1, 0, 2, 1, 2'd0);
    pushAt(cyc + 2, "over_hold2", 0, 0, 1, 0, 2, 1, 2'd0);
    @(negedge clk);
    player_pressed = 1'b0;
    @(negedge clk);

    doReset();
    repeat (2) @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    pushAt(t0 + 1, "gen_b", 1, 0, 0, 0, 1, 1, 2'd0);
    pushAt(t0 + 2, "on1_b", 1, 1, 0, 0, 1, 1, shown[0]);
    pushAt(t0 + 3, "on2_b", 1, 1, 0, 0, 1, 1, shown[0]);
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 3) @(negedge clk);
    doReset();
    launch(1);

    player_num = shown[0];
    player_pressed = 1'b1;
    start = 1'b1;
    showRound(cyc, 2, 1);
    player_num = shown[0];
    player_pressed = 1'b1;
    pushAt(cyc + 1, "mid_echo", 0, 0, 0, 0, 2, 1, 2'd0);
    @(negedge clk);
    player_pressed = 1'b0;
    @(negedge clk);
    player_num = shown[1];
    player_pressed = 1'b1;
    pushAt(cyc + 1, "win", 0, 0, 0, 1, 2, 1, 2'd0);
    pushAt(cyc + 2, "win_hold", 0, 0, 0, 1, 2, 1, 2'd0);
    @(negedge clk);
    player_pressed = 1'b0;
    @(negedge clk);
    start = 1'b1;
    showRound(cyc, 1, 0);

`ifdef SIMON_TIMEOUT_EN
    pushAt(cyc + 63, "pre_timeout", 0, 0, 0, 0, 1, 1, 2'd0);
    pushAt(cyc + 64, "timeout", 0, 0, 1, 0, 1, 1, 2'd0);
    repeat (66) @(negedge clk);
`else
    pushAt(cyc + 200, "no_timeout", 0, 0, 0, 0, 1, 1, 2'd0);
    repeat (202) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL leftover got %0d pending exp 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
